// File: rtl/membus_arbiter_pkg.sv
// Shared definitions for the two-requester memory bus arbiter.
// State/owner encodings and the request bundle muxed into the bus.
package membus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

    localparam int REGION_BIT = 15;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_req_t;

endpackage

// File: rtl/membus_waitctr.sv
// Loadable 4-bit wait-state down-counter; o_last flags the final
// ACCESS cycle. Load value picks ROM or RAM timing from the region bit.
module membus_waitctr #(
    parameter int ROM_WAIT = 2,
    parameter int RAM_WAIT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_ram,
    input  logic i_dec,
    output logic o_last
);

    localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_W = 4'(RAM_WAIT);

    logic [3:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_ram ? RAM_W : ROM_W;
        end else if (i_dec && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_last = (r_cnt == 4'd1);

endmodule

// File: rtl/membus_arbiter.sv
// CPU/DMA arbiter for the 64K ROM/RAM bus: IDLE -> ACCESS -> ACK.
// Every bus strobe and ack is driven straight from a flop.
module membus_arbiter
    import membus_arbiter_pkg::*;
#(
    parameter int ROM_WAIT     = 2,
    parameter int RAM_WAIT     = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        rom_cs_n,
    output logic        ram_cs_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic [1:0]  owner,
    output logic        rom_wr_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    logic [1:0]    r_state;
    logic [SW-1:0] r_starve;
    logic          r_we;
    logic [7:0]    r_rdata;
    logic          w_cpu_win;
    logic          w_grant;
    logic          w_last;
    logic          w_ram;
    bus_req_t      w_sel;

    // DMA only overrides a contending CPU once it has been starved
    assign w_cpu_win = cpu_req && !(dma_req && r_starve == LIM);
    assign w_grant   = (r_state == ST_IDLE) && (cpu_req || dma_req);
    assign w_sel     = w_cpu_win ? '{cpu_we, cpu_addr, cpu_wdata}
                                 : '{dma_we, dma_addr, dma_wdata};
    assign w_ram     = w_sel.addr[REGION_BIT];

    membus_waitctr #(
        .ROM_WAIT (ROM_WAIT),
        .RAM_WAIT (RAM_WAIT)
    ) u_waitctr (
        .i_clk  (i_clk),
        .i_rst  (reset),
        .i_load (w_grant),
        .i_ram  (w_ram),
        .i_dec  (r_state == ST_ACCESS),
        .o_last (w_last)
    );

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_starve   <= '0;
            r_we       <= 1'b0;
            r_rdata    <= 8'h00;
            owner      <= OWN_NONE;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 8'h00;
            rom_cs_n   <= 1'b1;
            ram_cs_n   <= 1'b1;
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            rom_wr_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        mem_addr  <= w_sel.addr;
                        mem_wdata <= w_sel.wdata;
                        r_we      <= w_sel.we;
                        owner     <= w_cpu_win ? OWN_CPU : OWN_DMA;
                        rom_cs_n  <= w_ram;
                        ram_cs_n  <= !w_ram;
                        mem_oe_n  <= w_sel.we;
                        // ROM is never strobed for write
                        mem_we_n  <= !(w_sel.we && w_ram);
                        if (w_sel.we && !w_ram) begin
                            rom_wr_err <= 1'b1;
                        end
                        if (!w_cpu_win) begin
                            r_starve <= '0;
                        end else if (dma_req && r_starve != LIM) begin
                            r_starve <= r_starve + 1'b1;
                        end
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (w_last) begin
                        if (!r_we) begin
                            r_rdata <= mem_rdata;
                        end
                        rom_cs_n <= 1'b1;
                        ram_cs_n <= 1'b1;
                        mem_oe_n <= 1'b1;
                        mem_we_n <= 1'b1;
                        cpu_ack  <= (owner == OWN_CPU);
                        dma_ack  <= (owner == OWN_DMA);
                        r_state  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    owner   <= OWN_NONE;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = r_rdata;
    assign dma_rdata = r_rdata;

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: transaction-level reference model with a
// per-cycle compare, directed scenarios and randomized CPU/DMA traffic.
module tb_membus_arbiter;

    localparam int ROM_W = 2;
    localparam int RAM_W = 1;
    localparam int LIM   = 8;

    logic        i_clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        cpu_ack, dma_ack;
    logic [7:0]  cpu_rdata, dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        rom_cs_n, ram_cs_n, mem_oe_n, mem_we_n;
    logic [1:0]  owner;
    logic        rom_wr_err;

    membus_arbiter #(
        .ROM_WAIT     (ROM_W),
        .RAM_WAIT     (RAM_W),
        .STARVE_LIMIT (LIM)
    ) dut (
        .i_clk      (i_clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_ack    (dma_ack),
        .dma_rdata  (dma_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rom_cs_n   (rom_cs_n),
        .ram_cs_n   (ram_cs_n),
        .mem_oe_n   (mem_oe_n),
        .mem_we_n   (mem_we_n),
        .owner      (owner),
        .rom_wr_err (rom_wr_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] rom_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h2C;
    endfunction

    logic [7:0] ram [0:32767];
    assign mem_rdata = mem_addr[15] ? ram[mem_addr[14:0]] : rom_val(mem_addr);

    always @(posedge i_clk) begin
        if (reset) begin
            for (int i = 0; i < 32768; i++) ram[i] <= 8'h00;
        end else if (!mem_we_n && !ram_cs_n) begin
            ram[mem_addr[14:0]] <= mem_wdata;
        end
    end

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            if (nerr <= 60)
                $display("FAIL %s at %0t: got %0h expected %0h",
                         nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  own;
        logic        rcs, acs, oe, we, cack, dack, err;
        logic        chk_addr, chk_wd, chk_rd;
        logic [15:0] addr;
        logic [7:0]  wd, rd;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    bit         model_ok = 1'b0;
    int         starve_m = 0;
    logic       err_m = 1'b0;
    logic [7:0] refmem [0:32767];

    function automatic exp_t idle_rec();
        exp_t e;
        e.own = 2'b00;
        e.rcs = 1'b1; e.acs = 1'b1; e.oe = 1'b1; e.we = 1'b1;
        e.cack = 1'b0; e.dack = 1'b0; e.err = err_m;
        e.chk_addr = 1'b0; e.chk_wd = 1'b0; e.chk_rd = 1'b0;
        e.addr = 16'h0; e.wd = 8'h0; e.rd = 8'h0;
        return e;
    endfunction

    task automatic model_step();
        exp_t        e;
        bit          dma_w, we, rgn;
        logic [15:0] a;
        logic [7:0]  d, rdx;
        int          w;
        if (reset) begin
            q.delete();
            starve_m = 0;
            err_m = 1'b0;
            for (int i = 0; i < 32768; i++) refmem[i] = 8'h00;
            cur = idle_rec();
            cur.chk_addr = 1'b1; cur.chk_wd = 1'b1; cur.chk_rd = 1'b1;
            model_ok = 1'b1;
            return;
        end
        if (!model_ok) return;
        if (q.size() > 0) begin
            cur = q.pop_front();
            return;
        end
        if (!cpu_req && !dma_req) begin
            cur = idle_rec();
            return;
        end
        dma_w = dma_req && (!cpu_req || starve_m == LIM);
        if (dma_w) starve_m = 0;
        else if (dma_req && starve_m < LIM) starve_m++;
        we = dma_w ? dma_we : cpu_we;
        a  = dma_w ? dma_addr : cpu_addr;
        d  = dma_w ? dma_wdata : cpu_wdata;
        rgn = a[15];
        w = rgn ? RAM_W : ROM_W;
        if (we && !rgn) err_m = 1'b1;
        rdx = rgn ? refmem[a[14:0]] : rom_val(a);
        if (we && rgn) refmem[a[14:0]] = d;
        for (int i = 0; i < w; i++) begin
            e = idle_rec();
            e.own = dma_w ? 2'b10 : 2'b01;
            e.rcs = rgn; e.acs = !rgn;
            e.oe = we; e.we = !(we && rgn);
            e.chk_addr = 1'b1; e.addr = a;
            e.chk_wd = we; e.wd = d;
            q.push_back(e);
        end
        e = idle_rec();
        e.own = dma_w ? 2'b10 : 2'b01;
        e.cack = !dma_w; e.dack = dma_w;
        e.chk_rd = !we; e.rd = rdx;
        q.push_back(e);
        q.push_back(idle_rec());
        cur = q.pop_front();
    endtask

    initial forever begin
        @(posedge i_clk);
        model_step();
    end

    initial forever begin
        @(negedge i_clk);
        if (model_ok) begin
            chk("owner", 32'(owner), 32'(cur.own));
            chk("rom_cs_n", 32'(rom_cs_n), 32'(cur.rcs));
            chk("ram_cs_n", 32'(ram_cs_n), 32'(cur.acs));
            chk("mem_oe_n", 32'(mem_oe_n), 32'(cur.oe));
            chk("mem_we_n", 32'(mem_we_n), 32'(cur.we));
            chk("cpu_ack", 32'(cpu_ack), 32'(cur.cack));
            chk("dma_ack", 32'(dma_ack), 32'(cur.dack));
            chk("rom_wr_err", 32'(rom_wr_err), 32'(cur.err));
            if (cur.chk_addr) chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
            if (cur.chk_wd) chk("mem_wdata", 32'(mem_wdata), 32'(cur.wd));
            if (cur.chk_rd) begin
                chk("cpu_rdata", 32'(cpu_rdata), 32'(cur.rd));
                chk("dma_rdata", 32'(dma_rdata), 32'(cur.rd));
            end
        end
    end

    task automatic xact(input bit dma, input logic we, input logic [15:0] a,
                        input logic [7:0] d, output int lat, output int ncs,
                        output int noe, output int nwe, output logic [7:0] rd,
                        output logic [15:0] aseen, output logic [7:0] dseen);
        bit done;
        done = 1'b0;
        lat = 0; ncs = 0; noe = 0; nwe = 0;
        rd = 8'h0; aseen = 16'h0; dseen = 8'h0;
        repeat (2) @(negedge i_clk);
        #1;
        if (dma) begin
            dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            lat++;
            if (!rom_cs_n || !ram_cs_n) begin
                ncs++; aseen = mem_addr; dseen = mem_wdata;
            end
            if (!mem_oe_n) noe++;
            if (!mem_we_n) nwe++;
            if (dma ? dma_ack : cpu_ack) begin
                rd = dma ? dma_rdata : cpu_rdata;
                done = 1'b1;
                break;
            end
        end
        #1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        chk("xact_ack_seen", 32'(done), 32'd1);
    endtask

    int          lat, ncs, noe, nwe, a1, a2, zeros, n;
    logic [7:0]  rd, dseen;
    logic [15:0] aseen;
    logic [9:0]  order;
    bit          cp, dp, seen, r;

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        repeat (3) @(negedge i_clk);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_strobes", 32'({rom_cs_n, ram_cs_n, mem_oe_n, mem_we_n}), 32'hF);
        chk("rst_acks", 32'({cpu_ack, dma_ack}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_err", 32'(rom_wr_err), 32'd0);
        #1 reset = 1'b0;

        xact(0, 0, 16'h0010, 8'h00, lat, ncs, noe, nwe, rd, aseen, dseen);
        chk("rom_rd_lat", 32'(lat), 32'd3);
        chk("rom_rd_cs", 32'(ncs), 32'd2);
        chk("rom_rd_oe", 32'(noe), 32'd2);
        chk("rom_rd_we", 32'(nwe), 32'd0);
        chk("rom_rd_data", 32'(rd), 32'h3C);

        xact(1, 1, 16'h8005, 8'hA7, lat, ncs, noe, nwe, rd, aseen, dseen);
        chk("dma_wr_lat", 32'(lat), 32'd2);
        chk("dma_wr_cs", 32'(ncs), 32'd1);
        chk("dma_wr_we", 32'(nwe), 32'd1);
        chk("dma_wr_oe", 32'(noe), 32'd0);
        chk("dma_wr_addr", 32'(aseen), 32'h8005);
        chk("dma_wr_data", 32'(dseen), 32'hA7);
        xact(0, 0, 16'h8005, 8'h00, lat, ncs, noe, nwe, rd, aseen, dseen);
        chk("ram_rd_back", 32'(rd), 32'hA7);
        chk("ram_rd_lat", 32'(lat), 32'd2);

        repeat (2) @(negedge i_clk);
        #1;
        cpu_we = 0; cpu_addr = 16'h8010; cpu_req = 1;
        dma_we = 0; dma_addr = 16'h8020; dma_req = 1;
        n = 0; order = '0;
        for (int i = 0; i < 200 && n < 10; i++) begin
            @(negedge i_clk);
            if (cpu_ack || dma_ack) begin
                order[n] = dma_ack;
                n++;
            end
        end
        #1;
        cpu_req = 0; dma_req = 0;
        chk("starve_grants", 32'(n), 32'd10);
        chk("starve_order", 32'(order), 32'h100);

        repeat (2) @(negedge i_clk);
        #1;
        cpu_we = 0; cpu_addr = 16'h8005; cpu_req = 1;
        a1 = -1; a2 = -1; zeros = 0;
        for (int i = 0; i < 40 && a2 < 0; i++) begin
            @(negedge i_clk);
            if (cpu_ack) begin
                if (a1 < 0) a1 = i; else a2 = i;
                chk("b2b_rdata", 32'(cpu_rdata), 32'hA7);
            end else if (a1 >= 0 && owner == 2'b00) begin
                zeros++;
            end
        end
        #1 cpu_req = 0;
        chk("b2b_spacing", 32'(a2 - a1), 32'd3);
        chk("b2b_idle", 32'(zeros), 32'd1);

        xact(0, 1, 16'h1234, 8'hFF, lat, ncs, noe, nwe, rd, aseen, dseen);
        chk("rom_wr_we", 32'(nwe), 32'd0);
        chk("rom_wr_oe", 32'(noe), 32'd0);
        chk("rom_wr_cs", 32'(ncs), 32'd2);
        chk("rom_wr_lat", 32'(lat), 32'd3);
        chk("rom_wr_err", 32'(rom_wr_err), 32'd1);

        cp = 0; dp = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge i_clk);
            if (cp && cpu_ack) cp = 0;
            if (dp && dma_ack) dp = 0;
            #1;
            if (!cp) begin
                if (c < 2900 && $urandom_range(0, 2) == 0) begin
                    r = 1'($urandom_range(0, 1));
                    cp = 1;
                    cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = {r, 11'h0, 4'($urandom_range(0, 15))};
                    cpu_wdata = 8'($urandom);
                    cpu_req = 1;
                end else begin
                    cpu_req = 0;
                end
            end
            if (!dp) begin
                if (c < 2900 && $urandom_range(0, 2) == 0) begin
                    r = 1'($urandom_range(0, 1));
                    dp = 1;
                    dma_we = 1'($urandom_range(0, 1));
                    dma_addr = {r, 11'h0, 4'($urandom_range(0, 15))};
                    dma_wdata = 8'($urandom);
                    dma_req = 1;
                end else begin
                    dma_req = 0;
                end
            end
        end
        chk("rand_drain", 32'({cp, dp}), 32'd0);
        chk("err_sticky", 32'(rom_wr_err), 32'd1);

        repeat (2) @(negedge i_clk);
        #1;
        cpu_we = 0; cpu_addr = 16'h0010; cpu_req = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge i_clk);
            if (!rom_cs_n) seen = 1;
        end
        chk("mid_access_reached", 32'(seen), 32'd1);
        #1;
        reset = 1; cpu_req = 0;
        @(negedge i_clk);
        chk("abort_strobes", 32'({rom_cs_n, ram_cs_n, mem_oe_n, mem_we_n}), 32'hF);
        chk("abort_owner", 32'(owner), 32'd0);
        chk("abort_ack", 32'(cpu_ack), 32'd0);
        chk("abort_err_clr", 32'(rom_wr_err), 32'd0);
        #1 reset = 0;
        seen = 0;
        repeat (4) begin
            @(negedge i_clk);
            if (cpu_ack) seen = 1;
        end
        chk("abort_no_ack", 32'(seen), 32'd0);
        chk("abort_idle", 32'(owner), 32'd0);
        xact(0, 0, 16'h0010, 8'h00, lat, ncs, noe, nwe, rd, aseen, dseen);
        chk("rereq_lat", 32'(lat), 32'd3);
        chk("rereq_data", 32'(rd), 32'h3C);

        repeat (3) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", nerr);
        $fatal(1);
    end

endmodule
